// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main control unit for the 18-bit CPU: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT sequencer.
// Optional build macro ILLEGAL_TRAP_EN: undefined opcodes trap to HALT and set the sticky illegal flag.
module multicycle_control_fsm #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       alu_ctrl,
  output logic             alu_src_b,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count,
  output logic [2:0]       state_dbg
);

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADDI = 4'h6;
  localparam logic [OP_W-1:0] OP_LW   = 4'h7;
  localparam logic [OP_W-1:0] OP_SW   = 4'h8;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic            retire_c;
  logic            trap_c;
  logic [OP_W-1:0] op;
  logic            unused_fields;

  // Only the opcode field steers control; register/immediate fields go to the datapath.
  assign op            = instr[WIDTH-1 -: OP_W];
  assign unused_fields = ^instr[WIDTH-OP_W-1:0];
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      retired_count <= '0;
      illegal       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire_c) retired_count <= retired_count + CNT_W'(1);
      if (trap_c)   illegal       <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    alu_ctrl  = ALU_ADD;
    alu_src_b = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_INC;
    ir_we     = 1'b0;
    iord      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    retire_c  = 1'b0;
    trap_c    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        case (op)
          OP_JMP: begin
            pc_we     = 1'b1;
            pc_src    = PC_JUMP;
            retire_c  = 1'b1;
            state_nxt = S_FETCH;
          end
          OP_HALT: begin
            retire_c  = 1'b1;
            state_nxt = S_HALT;
          end
          4'hB, 4'hC, 4'hD, 4'hE: begin
`ifdef ILLEGAL_TRAP_EN
            trap_c    = 1'b1;
            state_nxt = S_HALT;
`else
            retire_c  = 1'b1;
            state_nxt = S_FETCH;
`endif
          end
          default: state_nxt = S_EXECUTE;
        endcase
      end

      S_EXECUTE: begin
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            alu_ctrl  = op[2:0];
            state_nxt = S_WRITEBACK;
          end
          OP_ADDI: begin
            alu_src_b = 1'b1;
            state_nxt = S_WRITEBACK;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 1'b1;
            state_nxt = S_MEM;
          end
          OP_BEQ: begin
            alu_ctrl = ALU_SUB;
            if (zero) begin
              pc_we  = 1'b1;
              pc_src = PC_BRANCH;
            end
            retire_c  = 1'b1;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end

      // Request stays asserted until memory reports completion.
      S_MEM: begin
        iord = 1'b1;
        if (op == OP_LW) begin
          mem_re = 1'b1;
          if (mem_ready) state_nxt = S_WRITEBACK;
        end else if (op == OP_SW) begin
          mem_we = 1'b1;
          if (mem_ready) begin
            retire_c  = 1'b1;
            state_nxt = S_FETCH;
          end
        end else begin
          state_nxt = S_FETCH;
        end
      end

      S_WRITEBACK: begin
        reg_we    = 1'b1;
        wb_sel    = (op == OP_LW);
        retire_c  = 1'b1;
        state_nxt = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_nxt = S_FETCH;
    endcase

    // Reset overrides every state, including memory waits and HALT.
    if (rst) begin
      state_nxt = S_FETCH;
      alu_ctrl  = ALU_ADD;
      alu_src_b = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PC_INC;
      ir_we     = 1'b0;
      iord      = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;
      halted    = 1'b0;
      retire_c  = 1'b0;
      trap_c    = 1'b0;
    end
  end

endmodule
